disp_update_sched: RTL and testbench

Scheduler that shares the seven-segment display peripheral between two on-chip update sources and the CPU. It takes a 16-bit display value from whichever requester wins round-robin arbitration. It then issues two single-cycle bus writes: high byte to the left-byte register (0xD0), low byte to the right-byte register (0xD1). It yields the bus to the CPU whenever the CPU claims it, and rate-limits updates with a hold-off interval. It sits between the requesters and the shared bus mux in front of the LED display block.

---
 rtl/disp_update_sched.sv | 139 +++++++++++++
 tb/tb_disp_update_sched.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_update_sched.sv
`timescale 1ns/1ps
// Round-robin scheduler feeding two requesters' 16-bit values to the display as hi/lo byte writes.
// Grant to ACK is 3 edges, CPU bus claims stall the write FSM, and a hold-off follows each update.
module disp_update_sched #(
  parameter logic [7:0]  ADDR_HI     = 8'hD0,
  parameter logic [7:0]  ADDR_LO     = 8'hD1,
  parameter logic [7:0]  IDLE_ADDR   = 8'hFF,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic [15:0] data0_i,
  input  logic [15:0] data1_i,
  input  logic        cpu_bus_req_i,
  output logic        ack0_o,
  output logic        ack1_o,
  output logic [7:0]  bus_addr_o,
  output logic [7:0]  bus_data_o,
  output logic        bus_we_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_HI,
    S_WR_LO,
    S_DONE,
    S_HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      value_q, value_d;
  logic             gnt_q, gnt_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic             we_q, we_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             busy_q, busy_d;
  logic             gnt_sel;

  // On a tie the requester that did not win last time is chosen.
  assign gnt_sel = (req0_i && req1_i) ? ~last_q : req1_i;

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    addr_d  = IDLE_ADDR;
    data_d  = 8'h00;
    we_d    = 1'b0;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0_i || req1_i) begin
          gnt_d   = gnt_sel;
          last_d  = gnt_sel;
          value_d = gnt_sel ? data1_i : data0_i;
          state_d = S_WR_HI;
        end
      end
      S_WR_HI: begin
        if (!cpu_bus_req_i) begin
          addr_d  = ADDR_HI;
          data_d  = value_q[15:8];
          we_d    = 1'b1;
          state_d = S_WR_LO;
        end
      end
      S_WR_LO: begin
        if (!cpu_bus_req_i) begin
          addr_d  = ADDR_LO;
          data_d  = value_q[7:0];
          we_d    = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        ack0_d  = ~gnt_q;
        ack1_d  = gnt_q;
        cnt_d   = CNT_W'(HOLD_CYCLES);
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      value_q <= 16'h0000;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      addr_q  <= IDLE_ADDR;
      data_q  <= 8'h00;
      we_q    <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      busy_q  <= busy_d;
    end
  end

  assign ack0_o     = ack0_q;
  assign ack1_o     = ack1_q;
  assign bus_addr_o = addr_q;
  assign bus_data_o = data_q;
  assign bus_we_o   = we_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_disp_update_sched.sv
`timescale 1ns/1ps
// Scoreboard bench: stimulus pushes expected bus writes and ACKs (with their cycle); a monitor pops and compares.
module tb_disp_update_sched;

  typedef struct {
    int         cyc;
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    int cyc;
    int id;
  } ack_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, cpu = 1'b0, zreq1 = 1'b0;
  logic [15:0] data0 = 16'h0, data1 = 16'h0, zdata1 = 16'h0;
  logic        ack0, ack1, we, busy;
  logic [7:0]  addr, bdat;
  logic        zack0, zack1, zwe, zbusy;
  logic [7:0]  zaddr, zbdat;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  wr_t  wq[$], zwq[$];
  ack_t aq[$], zaq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  disp_update_sched dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_i(req0), .req1_i(req1), .data0_i(data0), .data1_i(data1),
    .cpu_bus_req_i(cpu),
    .ack0_o(ack0), .ack1_o(ack1),
    .bus_addr_o(addr), .bus_data_o(bdat), .bus_we_o(we), .busy_o(busy)
  );

  disp_update_sched #(.HOLD_CYCLES(0)) dut_z (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_i(1'b0), .req1_i(zreq1), .data0_i(16'h0000), .data1_i(zdata1),
    .cpu_bus_req_i(1'b0),
    .ack0_o(zack0), .ack1_o(zack1),
    .bus_addr_o(zaddr), .bus_data_o(zbdat), .bus_we_o(zwe), .busy_o(zbusy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_wr(input int c, input logic [7:0] a, input logic [7:0] d);
    wr_t w;
    w.cyc = c; w.addr = a; w.data = d;
    wq.push_back(w);
  endtask

  task automatic push_ack(input int c, input int id);
    ack_t k;
    k.cyc = c; k.id = id;
    aq.push_back(k);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; cpu = 1'b0; zreq1 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every write/ACK the DUTs present must match the head of its queue.
  initial begin
    wr_t  w;
    ack_t k;
    logic       prev_we = 1'b0;
    logic [7:0] prev_addr = 8'hFF;
    forever begin
      @(negedge clk);
      if (we) begin
        if (wq.size() == 0) check("wr_unexpected", {addr, bdat}, 16'h0);
        else begin
          w = wq.pop_front();
          check("wr_cycle", cyc, w.cyc);
          check("wr_addr", addr, w.addr);
          check("wr_data", bdat, w.data);
        end
        check("we_same_addr_twice", prev_we && (prev_addr == addr), 0);
      end
      prev_we = we;
      prev_addr = addr;
      if (ack0 || ack1) begin
        check("ack_both", ack0 && ack1, 0);
        if (aq.size() == 0) check("ack_unexpected", {ack1, ack0}, 0);
        else begin
          k = aq.pop_front();
          check("ack_cycle", cyc, k.cyc);
          check("ack_id", ack1 ? 1 : 0, k.id);
        end
      end
      if (zwe) begin
        if (zwq.size() == 0) check("zwr_unexpected", {zaddr, zbdat}, 16'h0);
        else begin
          w = zwq.pop_front();
          check("zwr_cycle", cyc, w.cyc);
          check("zwr_addr", zaddr, w.addr);
          check("zwr_data", zbdat, w.data);
        end
      end
      if (zack0 || zack1) begin
        if (zaq.size() == 0) check("zack_unexpected", {zack1, zack0}, 0);
        else begin
          k = zaq.pop_front();
          check("zack_cycle", cyc, k.cyc);
          check("zack_id", zack1 ? 1 : 0, k.id);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, expected finish within 10000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g;
    int g2;
    wr_t  w;
    ack_t k;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_addr", addr, 8'hFF);
    check("rst_data", bdat, 8'h00);
    check("rst_we", we, 0);
    check("rst_ack", {ack1, ack0}, 0);
    check("rst_busy", busy, 0);
    check("rst_z_we", zwe, 0);
    rst_n = 1'b1;

    // Single update: FFF0 from requester 0
    data0 = 16'hFFF0; req0 = 1'b1;
    g = cyc + 1;
    push_wr(g + 1, 8'hD0, 8'hFF);
    push_wr(g + 2, 8'hD1, 8'hF0);
    push_ack(g + 3, 0);
    wait_cyc(g);
    check("busy_after_grant", busy, 1);
    wait_cyc(g + 3);
    req0 = 1'b0;
    wait_cyc(g + 21);
    check("busy_after_hold", busy, 0);

    // Tie arbitration, grants 21 edges apart
    do_reset();
    data0 = 16'h1234; data1 = 16'hABCD; req0 = 1'b1; req1 = 1'b1;
    g = cyc + 1;
    push_wr(g + 1, 8'hD0, 8'h12);  push_wr(g + 2, 8'hD1, 8'h34);  push_ack(g + 3, 0);
    push_wr(g + 22, 8'hD0, 8'hAB); push_wr(g + 23, 8'hD1, 8'hCD); push_ack(g + 24, 1);
    push_wr(g + 43, 8'hD0, 8'h12); push_wr(g + 44, 8'hD1, 8'h34); push_ack(g + 45, 0);
    wait_cyc(g + 45);
    req0 = 1'b0; req1 = 1'b0;

    // CPU holds the bus for 3 cycles while in WR_LO
    do_reset();
    data0 = 16'hC3A5; req0 = 1'b1;
    g = cyc + 1;
    push_wr(g + 1, 8'hD0, 8'hC3);
    push_wr(g + 5, 8'hD1, 8'hA5);
    push_ack(g + 6, 0);
    wait_cyc(g + 1);
    cpu = 1'b1;
    wait_cyc(g + 4);
    cpu = 1'b0;
    wait_cyc(g + 6);
    req0 = 1'b0;

    // Data change after grant is ignored
    do_reset();
    data0 = 16'h00AA; req0 = 1'b1;
    g = cyc + 1;
    push_wr(g + 1, 8'hD0, 8'h00);
    push_wr(g + 2, 8'hD1, 8'hAA);
    push_ack(g + 3, 0);
    wait_cyc(g);
    data0 = 16'h5555;
    wait_cyc(g + 3);
    req0 = 1'b0;

    // Reset right after the high-byte write, then a fresh REQ1
    do_reset();
    data0 = 16'h2468; req0 = 1'b1;
    g = cyc + 1;
    push_wr(g + 1, 8'hD0, 8'h24);
    wait_cyc(g + 1);
    rst_n = 1'b0;
    wait_cyc(g + 2);
    check("midrst_we", we, 0);
    check("midrst_addr", addr, 8'hFF);
    check("midrst_busy", busy, 0);
    rst_n = 1'b1; req0 = 1'b0;
    data1 = 16'h1357; req1 = 1'b1;
    g2 = cyc + 1;
    push_wr(g2 + 1, 8'hD0, 8'h13);
    push_wr(g2 + 2, 8'hD1, 8'h57);
    push_ack(g2 + 3, 1);
    wait_cyc(g2 + 3);
    req1 = 1'b0;
    wait_cyc(g2 + 25);

    // Zero hold-off instance: grants every 5 edges
    do_reset();
    zdata1 = 16'h0F5A; zreq1 = 1'b1;
    g = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      w.cyc = g + 5 * i + 1; w.addr = 8'hD0; w.data = 8'h0F; zwq.push_back(w);
      w.cyc = g + 5 * i + 2; w.addr = 8'hD1; w.data = 8'h5A; zwq.push_back(w);
      k.cyc = g + 5 * i + 3; k.id = 1; zaq.push_back(k);
    end
    wait_cyc(g + 13);
    zreq1 = 1'b0;
    wait_cyc(g + 25);

    check("wq_drained", wq.size(), 0);
    check("aq_drained", aq.size(), 0);
    check("zwq_drained", zwq.size(), 0);
    check("zaq_drained", zaq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
